load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width; only 32 is supported.
REQ-002 SHALL have parameter ADDR_W, default 32, meaning data-memory byte-address width.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req_valid_i  input  1  execute stage offers a memory op.
REQ-006 SHALL have port req_ready_o  output  1  LSU can accept; high only in IDLE.
REQ-007 SHALL have port ctrl_i  input  core_ctrl_t  decoded control; uses load_sel, store_sel, load_op, store_op, addr.rd_addr.
REQ-008 SHALL have port addr_i  input  ADDR_W  effective byte address (ALU result).
REQ-009 SHALL have port wdata_i  input  XLEN  store data (rs2 value).
REQ-010 SHALL have ports dmem_req_o output 1, dmem_we_o output 1, dmem_be_o output 4, dmem_addr_o output ADDR_W (word-aligned), dmem_wdata_o output XLEN: data-memory request.
REQ-011 SHALL have ports dmem_gnt_i input 1, dmem_rvalid_i input 1, dmem_rdata_i input XLEN: data-memory grant and response.
REQ-012 SHALL have ports wb_valid_o output 1, wb_rd_o output 5, wb_data_o output XLEN: load writeback.
REQ-013 SHALL have port err_o  output  1  one-cycle pulse on misaligned or illegal op.
REQ-014 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, REQ, WAIT_R.
REQ-016 SHALL accept a request in IDLE when req_valid_i & req_ready_o & (load_sel ^ store_sel); it SHALL latch ctrl_i, addr_i and wdata_i on acceptance.
REQ-017 SHALL pulse err_o the cycle after acceptance and stay in IDLE, without a dmem request, when: halfword op with addr_i[0]=1; word op with addr_i[1:0]!=0; load_op LD or LWU; store_op not SB/SH/SW.
REQ-018 SHALL pulse err_o and stay in IDLE when load_sel and store_sel are both high with req_valid_i.
REQ-019 SHALL move IDLE->REQ on a legal acceptance; in REQ dmem_req_o=1, and addr/we/be/wdata SHALL stay stable until dmem_gnt_i.
REQ-020 SHALL, in REQ on dmem_gnt_i: for a store, go to IDLE; for a load, go to WAIT_R, or to IDLE with writeback if dmem_rvalid_i is high in the same cycle.
REQ-021 SHALL, in WAIT_R on dmem_rvalid_i, register the extended data and pulse wb_valid_o for exactly one cycle next cycle, then go to IDLE.
REQ-022 SHALL ignore dmem_rvalid_i in IDLE and in REQ before grant.
REQ-023 SHALL build stores as: SB be=4'b0001<<addr[1:0], wdata={4{b}}; SH be=4'b0011<<{addr[1],1'b0}, wdata={2{h}}; SW be=4'b1111.
REQ-024 SHALL shift loads as rdata>>(8*addr[1:0]); LB/LH sign-extend; LBU/LHU zero-extend; LW pass-through.
REQ-025 SHALL set dmem_addr_o to {addr[ADDR_W-1:2],2'b00}.
REQ-026 SHALL perform the access for a load with rd=x0 but SHALL NOT assert wb_valid_o.
REQ-027 SHALL give minimum latency: load accepted at cycle T, with grant at T+1 and rvalid at T+2, produces wb_valid_o at T+3; a store is back in IDLE at T+2.

Reset
REQ-028 SHALL, on rst, enter IDLE and drive dmem_req_o, dmem_we_o, wb_valid_o, err_o and busy_o to 0, and dmem_be_o, dmem_addr_o, dmem_wdata_o, wb_rd_o and wb_data_o to 0.
REQ-029 SHALL abandon any in-flight transaction when rst is asserted mid-operation; a later dmem_rvalid_i SHALL be ignored per REQ-022.

Structure
REQ-030 SHALL place lsu_state_t (IDLE/REQ/WAIT_R) and the byte-enable width constant in core_pkg.
REQ-031 SHALL place the combinational lane/extension logic in one sub-module, lsu_data_align.

Verification
REQ-032 SB: addr=0x1003, wdata=0xAABBCCDD, gnt immediate -> be=4'b1000, wdata=0xDDDDDDDD, dmem_addr=0x1000.
REQ-033 LB: addr=0x2001, rdata=0x0000_8000, rd=x5 -> wb_data=0xFFFFFF80, wb_rd=5, wb_valid one cycle.
REQ-034 LHU: addr=0x2002, rdata=0xBEEF1234 -> wb_data=0x0000BEEF.
REQ-035 LW: addr=0x2002 -> err_o pulse, no dmem_req_o, req_ready_o stays 1.
REQ-036 SW: gnt withheld 3 cycles -> dmem_req/addr/wdata/be stable for all 4 cycles, busy_o=1 until grant.
REQ-037 LW: rst asserted in WAIT_R, rvalid arrives 2 cycles later -> IDLE, no wb_valid_o.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core types used by the load/store unit:
// decoded control, memory op encodings, LSU states, and the legality check.
package core_pkg;

    localparam int BE_W   = 4;
    localparam int WORD_W = 32;

    typedef enum logic [1:0] {IDLE, REQ, WAIT_R} lsu_state_t;

    typedef enum logic [2:0] {LB, LH, LW, LBU, LHU, LWU, LD} load_op_t;
    typedef enum logic [1:0] {SB, SH, SW, SD} store_op_t;

    typedef struct packed {
        logic [4:0] rd_addr;
    } reg_addr_t;

    typedef struct packed {
        logic      load_sel;
        logic      store_sel;
        load_op_t  load_op;
        store_op_t store_op;
        reg_addr_t addr;
    } core_ctrl_t;

    // Misaligned access or an op this 32-bit unit does not implement.
    function automatic logic lsu_bad_op(input core_ctrl_t c, input logic [1:0] a);
        logic bad;
        bad = 1'b0;
        if (c.load_sel) begin
            case (c.load_op)
                LB, LBU: bad = 1'b0;
                LH, LHU: bad = a[0];
                LW:      bad = (a != 2'b00);
                default: bad = 1'b1;
            endcase
        end else begin
            case (c.store_op)
                SB:      bad = 1'b0;
                SH:      bad = a[0];
                SW:      bad = (a != 2'b00);
                default: bad = 1'b1;
            endcase
        end
        return bad;
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Lane-alignment bundle between the LSU control path and its data aligner.
// master: drives the latched op, byte offset and raw data; slave: returns lanes.
interface load_store_unit_if;
    import core_pkg::*;

    load_op_t           ld_op;
    store_op_t          st_op;
    logic [1:0]         addr_lo;
    logic [WORD_W-1:0]  wdata;
    logic [WORD_W-1:0]  rdata;
    logic [BE_W-1:0]    be;
    logic [WORD_W-1:0]  st_data;
    logic [WORD_W-1:0]  ld_data;

    modport master (output ld_op, st_op, addr_lo, wdata, rdata,
                    input  be, st_data, ld_data);
    modport slave  (input  ld_op, st_op, addr_lo, wdata, rdata,
                    output be, st_data, ld_data);

endinterface

// File: rtl/lsu_data_align.sv
// Combinational byte-lane steering: store replication + byte enables,
// load shift + sign/zero extension.
module lsu_data_align
    import core_pkg::*;
(
    load_store_unit_if.slave bus
);

    logic [WORD_W-1:0] shifted;

    // Bring the addressed byte/halfword down to bit 0 of the returned word.
    always_comb begin
        shifted = bus.rdata >> {bus.addr_lo, 3'b000};
    end

    // Store lanes: replicate the datum across the word, enable only the target bytes.
    always_comb begin
        bus.be      = '0;
        bus.st_data = '0;
        case (bus.st_op)
            SB: begin
                bus.be      = 4'b0001 << bus.addr_lo;
                bus.st_data = {4{bus.wdata[7:0]}};
            end
            SH: begin
                bus.be      = 4'b0011 << {bus.addr_lo[1], 1'b0};
                bus.st_data = {2{bus.wdata[15:0]}};
            end
            SW: begin
                bus.be      = '1;
                bus.st_data = bus.wdata;
            end
            default: ;
        endcase
    end

    // Load extension by op width and signedness.
    always_comb begin
        bus.ld_data = '0;
        case (bus.ld_op)
            LB:      bus.ld_data = {{24{shifted[7]}}, shifted[7:0]};
            LBU:     bus.ld_data = {24'b0, shifted[7:0]};
            LH:      bus.ld_data = {{16{shifted[15]}}, shifted[15:0]};
            LHU:     bus.ld_data = {16'b0, shifted[15:0]};
            LW:      bus.ld_data = shifted;
            default: ;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit: accepts one op in IDLE, issues it on the
// data-memory bus, waits for grant (and read data for loads), writes back loads.
module load_store_unit
    import core_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  core_ctrl_t        ctrl_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [BE_W-1:0]   dmem_be_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [XLEN-1:0]   dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [XLEN-1:0]   dmem_rdata_i,
    output logic              wb_valid_o,
    output logic [4:0]        wb_rd_o,
    output logic [XLEN-1:0]   wb_data_o,
    output logic              err_o,
    output logic              busy_o
);

    lsu_state_t        state_q, state_d;
    core_ctrl_t        ctrl_q;
    logic [ADDR_W-1:0] addr_q;
    logic [XLEN-1:0]   wdata_q;
    logic              sel_one, sel_both, bad_op;
    logic              accept, capture, in_req;
    logic              err_q, wb_valid_q;
    logic [4:0]        wb_rd_q;
    logic [XLEN-1:0]   wb_data_q;

    load_store_unit_if aif ();

    assign aif.ld_op   = ctrl_q.load_op;
    assign aif.st_op   = ctrl_q.store_op;
    assign aif.addr_lo = addr_q[1:0];
    assign aif.wdata   = wdata_q;
    assign aif.rdata   = dmem_rdata_i;

    lsu_data_align u_align (.bus(aif.slave));

    assign sel_one  = ctrl_i.load_sel ^ ctrl_i.store_sel;
    assign sel_both = ctrl_i.load_sel & ctrl_i.store_sel;
    assign bad_op   = lsu_bad_op(ctrl_i, addr_i[1:0]);

    // Next state; rvalid only counts once the request has been granted.
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        capture = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid_i && sel_one) begin
                    accept = 1'b1;
                    if (!bad_op) state_d = REQ;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    if (ctrl_q.store_sel) begin
                        state_d = IDLE;
                    end else if (dmem_rvalid_i) begin
                        capture = 1'b1;
                        state_d = IDLE;
                    end else begin
                        state_d = WAIT_R;
                    end
                end
            end
            WAIT_R: begin
                if (dmem_rvalid_i) begin
                    capture = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Operand capture on acceptance; held stable while the bus request is open.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (accept) begin
            ctrl_q  <= ctrl_i;
            addr_q  <= addr_i;
            wdata_q <= wdata_i;
        end
    end

    // Error pulse and load writeback registers (x0 loads complete silently).
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q      <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
        end else begin
            err_q      <= (state_q == IDLE) && req_valid_i &&
                          (sel_both || (sel_one && bad_op));
            wb_valid_q <= capture && (ctrl_q.addr.rd_addr != 5'd0);
            if (capture) begin
                wb_rd_q   <= ctrl_q.addr.rd_addr;
                wb_data_q <= aif.ld_data;
            end
        end
    end

    assign in_req       = (state_q == REQ);
    assign dmem_req_o   = in_req;
    assign dmem_we_o    = in_req && ctrl_q.store_sel;
    assign dmem_be_o    = dmem_we_o ? aif.be : '0;
    assign dmem_addr_o  = in_req ? {addr_q[ADDR_W-1:2], 2'b00} : '0;
    assign dmem_wdata_o = dmem_we_o ? aif.st_data : '0;
    assign req_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign err_o        = err_q;
    assign wb_valid_o   = wb_valid_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_data_o    = wb_data_q;

endmodule
